// File: rtl/serial_rx_buffer.sv
// Byte FIFO between the UART receiver and the MMU serial read path. Each rising edge of
// rx_complete_i stores one byte. The oldest byte is shown ahead on data_o, and overflow is sticky.
module serial_rx_buffer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_complete_i,
   input  logic [7:0]        rx_data_i,
   input  logic              pop_i,
   input  logic              clear_i,
   output logic [15:0]       data_o,
   output logic              data_ready_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              overflow_o
);

   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   count;
   logic              rx_prev;
   logic              overflow;
   logic              push_req;
   logic              empty;
   logic              full;
   logic              do_push;
   logic              do_pop;

   // rx_complete_i is a level that may last several cycles, so only its rising edge pushes
   assign push_req = rx_complete_i & ~rx_prev;
   assign empty    = (count == '0);
   assign full     = (count == CNT_FULL);

   // A pop on a full FIFO frees the head slot, so a push in the same cycle is accepted
   assign do_pop  = pop_i & ~clear_i & ~empty;
   assign do_push = push_req & ~clear_i & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rx_prev  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rx_prev <= rx_complete_i;
         if (clear_i) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            if (do_push) begin
               wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
               rptr <= rptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
               count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
               count <= count - CNT_ONE;
            end
            if (push_req && full && !do_pop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= rx_data_i;
      end
   end

   assign data_o       = empty ? 16'h0000 : {8'h00, mem[rptr]};
   assign data_ready_o = ~empty;
   assign count_o      = count;
   assign full_o       = full;
   assign overflow_o   = overflow;

endmodule

// File: tb/tb_serial_rx_buffer.sv
// Scoreboard bench for serial_rx_buffer. A queue-based reference model is updated as stimulus
// is issued, and two monitors compare the per-cycle status and each popped byte.
module tb_serial_rx_buffer;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst;
   logic        rx_complete_i;
   logic [7:0]  rx_data_i;
   logic        pop_i;
   logic        clear_i;
   logic [15:0] data_o;
   logic        data_ready_o;
   logic [4:0]  count_o;
   logic        full_o;
   logic        overflow_o;

   serial_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_complete_i (rx_complete_i),
      .rx_data_i     (rx_data_i),
      .pop_i         (pop_i),
      .clear_i       (clear_i),
      .data_o        (data_o),
      .data_ready_o  (data_ready_o),
      .count_o       (count_o),
      .full_o        (full_o),
      .overflow_o    (overflow_o)
   );

   typedef struct packed {
      logic [4:0]  cnt;
      logic        ovf;
      logic [15:0] dat;
   } st_t;

   st_t        exp_st[$];
   logic [7:0] exp_pop[$];
   logic [7:0] model_q[$];
   logic       model_ovf;
   logic       model_prev;
   int         checks;
   int         errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic st_t model_status();
      st_t s;
      s.cnt = 5'(model_q.size());
      s.ovf = model_ovf;
      s.dat = (model_q.size() > 0) ? {8'h00, model_q[0]} : 16'h0000;
      return s;
   endfunction

   // One clock of stimulus, issued at a falling edge; the model predicts the state after the next rising edge
   task automatic step(input logic rc, input logic [7:0] rd, input logic pp, input logic cl);
      logic push;
      logic can_pop;
      rx_complete_i = rc;
      rx_data_i     = rd;
      pop_i         = pp;
      clear_i       = cl;
      push       = rc && !model_prev;
      model_prev = rc;
      if (cl) begin
         model_q.delete();
         exp_pop.delete();
         model_ovf = 1'b0;
      end else begin
         can_pop = pp && (model_q.size() > 0);
         if (push) begin
            if (model_q.size() < DEPTH || can_pop) begin
               model_q.push_back(rd);
               exp_pop.push_back(rd);
            end else begin
               model_ovf = 1'b1;
            end
         end
         if (can_pop) begin
            void'(model_q.pop_front());
         end
      end
      exp_st.push_back(model_status());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pops(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // Reset is raised between clock edges, so outputs must clear before any rising edge
   task automatic reset_mid();
      rst           = 1'b1;
      rx_complete_i = 1'b0;
      pop_i         = 1'b0;
      clear_i       = 1'b0;
      model_q.delete();
      exp_pop.delete();
      model_ovf  = 1'b0;
      model_prev = 1'b0;
      #1;
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_ready", 32'(data_ready_o), 32'd0);
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      exp_st.push_back(model_status());
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Status monitor: compares the state left by each rising edge
   initial begin
      st_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_st.size() > 0) begin
            e = exp_st.pop_front();
            chk("count", 32'(count_o), 32'(e.cnt));
            chk("overflow", 32'(overflow_o), 32'(e.ovf));
            chk("full", 32'(full_o), 32'(e.cnt == 5'd16));
            chk("ready", 32'(data_ready_o), 32'(e.cnt != 5'd0));
            chk("head", 32'(data_o), 32'(e.dat));
         end
      end
   end

   // Read monitor: each accepted pop must present the oldest expected byte
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && pop_i && !clear_i && data_ready_o) begin
            if (exp_pop.size() == 0) begin
               chk("pop_unexpected", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
               b = exp_pop.pop_front();
               chk("pop_data", 32'(data_o), {24'h0, b});
            end
         end
      end
   end

   initial begin
      int r;
      int pop_pct;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      rx_complete_i = 1'b0;
      rx_data_i     = 8'h00;
      pop_i         = 1'b0;
      clear_i       = 1'b0;
      model_ovf     = 1'b0;
      model_prev    = 1'b0;
      #3;
      chk("init_count", 32'(count_o), 32'd0);
      chk("init_data", 32'(data_o), 32'd0);
      chk("init_ready", 32'(data_ready_o), 32'd0);
      chk("init_full", 32'(full_o), 32'd0);
      chk("init_overflow", 32'(overflow_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // A held receive flag yields exactly one entry
      repeat (5) step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      pops(1);

      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      pops(3);
      idle(1);

      for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
      pops(17);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Full FIFO with simultaneous push and pop, run long enough to wrap the pointers
      for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
      for (int i = 0; i < 40; i++) begin
         step(1'b1, (i == 0) ? 8'h77 : 8'($urandom), 1'b1, 1'b0);
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      pops(17);

      pops(3);
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      pops(1);

      // Clear with a concurrent push edge, then an asynchronous reset mid-stream
      for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i));
      pops(12);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      idle(2);
      push_byte(8'h61);
      push_byte(8'h62);
      push_byte(8'h63);
      step(1'b1, 8'h64, 1'b0, 1'b0);
      reset_mid();
      idle(2);

      for (int phase = 0; phase < 2; phase++) begin
         pop_pct = (phase == 0) ? 10 : 50;
         repeat (400) begin
            r = $urandom_range(199);
            if (r == 0) begin
               reset_mid();
            end else begin
               step(1'($urandom_range(1)), 8'($urandom),
                    1'($urandom_range(99) < pop_pct), 1'($urandom_range(99) < 2));
            end
         end
      end
      idle(2);

      for (int i = 0; i < 10 && exp_st.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_st.size() > 0) begin
         chk("status_drain", 32'(exp_st.size()), 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
